// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: buffers droppable prefetch requests and issues them below demand priority.
// Optional PF_DEDUP_EN drops requests whose line already sits valid in the queue.
module prefetch_issue_queue #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 8,
    parameter int LOGLINE   = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     pf_address_i,
    input  logic                 pf_valid_i,
    output logic                 pf_ready_o,
    input  logic [WIDTH-1:0]     dmd_address_i,
    input  logic                 dmd_valid_i,
    output logic [WIDTH-1:0]     lo_address_o,
    output logic                 lo_valid_o,
    input  logic                 lo_ready_i,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    output logic [CNT_WIDTH-1:0] issue_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0]     r_addr [DEPTH];
    logic [DEPTH-1:0]     r_v;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [PW:0]          r_count;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [CNT_WIDTH-1:0] r_issue_cnt;

    logic                 w_nonempty;
    logic                 w_full;
    logic                 w_lo_valid;
    logic                 w_issue;
    logic                 w_pop;
    logic                 w_dup;
    logic                 w_dmd_hit_pf;
    logic                 w_accept;
    logic                 w_drop;
    logic [DEPTH-1:0]     w_cancel;

    always_comb begin
        w_nonempty   = (r_count != '0);
        w_full       = (r_count == FULL_CNT);
        w_lo_valid   = w_nonempty & r_v[r_head] & ~dmd_valid_i;
        w_issue      = w_lo_valid & lo_ready_i;
        // A cancelled head is retired silently, one dead entry per cycle.
        w_pop        = w_issue | (w_nonempty & ~r_v[r_head]);
        w_dmd_hit_pf = dmd_valid_i &
                       (pf_address_i[WIDTH-1:LOGLINE] == dmd_address_i[WIDTH-1:LOGLINE]);
        w_dup        = 1'b0;
        w_cancel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cancel[i] = dmd_valid_i &
                          (r_addr[i][WIDTH-1:LOGLINE] == dmd_address_i[WIDTH-1:LOGLINE]);
`ifdef PF_DEDUP_EN
            if (r_v[i] && (r_addr[i][WIDTH-1:LOGLINE] == pf_address_i[WIDTH-1:LOGLINE]))
                w_dup = 1'b1;
`endif
        end
        // Full is judged on the registered count, so a same-cycle pop never admits a request.
        w_accept     = pf_valid_i & ~w_full & ~w_dmd_hit_pf & ~w_dup;
        w_drop       = pf_valid_i & ~w_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
            r_v         <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_drop_cnt  <= '0;
            r_issue_cnt <= '0;
        end else begin
            // Entries outside the live window always have v=0, so cancelling every match is safe.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cancel[i]) r_v[i] <= 1'b0;
            end
            if (w_pop) begin
                r_v[r_head] <= 1'b0;
                r_head      <= r_head + 1'b1;
            end
            if (w_accept) begin
                r_addr[r_tail] <= pf_address_i;
                r_v[r_tail]    <= 1'b1;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_accept && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop)
                r_count <= r_count - 1'b1;
            if (w_drop && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_issue && (r_issue_cnt != '1))
                r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    assign pf_ready_o   = ~w_full;
    assign lo_valid_o   = w_lo_valid;
    assign lo_address_o = r_addr[r_head];
    assign drop_cnt_o   = r_drop_cnt;
    assign issue_cnt_o  = r_issue_cnt;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Self-checking bench for prefetch_issue_queue: directed scenarios plus random traffic
// compared every cycle against a queue-of-entries reference model.
module tb_prefetch_issue_queue;
    localparam int W  = 64;
    localparam int D  = 8;
    localparam int LL = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  pf_address_i = '0;
    logic          pf_valid_i = 1'b0;
    logic          pf_ready_o;
    logic [W-1:0]  dmd_address_i = '0;
    logic          dmd_valid_i = 1'b0;
    logic [W-1:0]  lo_address_o;
    logic          lo_valid_o;
    logic          lo_ready_i = 1'b0;
    logic [CW-1:0] drop_cnt_o;
    logic [CW-1:0] issue_cnt_o;

    prefetch_issue_queue #(.WIDTH(W), .DEPTH(D), .LOGLINE(LL), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pf_address_i  (pf_address_i),
        .pf_valid_i    (pf_valid_i),
        .pf_ready_o    (pf_ready_o),
        .dmd_address_i (dmd_address_i),
        .dmd_valid_i   (dmd_valid_i),
        .lo_address_o  (lo_address_o),
        .lo_valid_o    (lo_valid_o),
        .lo_ready_i    (lo_ready_i),
        .drop_cnt_o    (drop_cnt_o),
        .issue_cnt_o   (issue_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] addr;
        bit           live;
    } ent_t;

    ent_t         mq[$];
    int           m_drop;
    int           m_issue;
    int           errors;
    int           checks;
    logic         obs_v;
    logic [W-1:0] obs_a;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] line_of(input logic [W-1:0] a);
        return a >> LL;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model across posedge.
    task automatic cycle(input bit pv, input logic [W-1:0] pa, input bit dv,
                         input logic [W-1:0] da, input bit rdy);
        bit lv, pop, dup, acc;
        @(negedge clk);
        pf_valid_i    = pv;
        pf_address_i  = pa;
        dmd_valid_i   = dv;
        dmd_address_i = da;
        lo_ready_i    = rdy;
        #1;
        lv = (mq.size() != 0) && mq[0].live && !dv;
        check("lo_valid", lo_valid_o, lv);
        if (lv) check("lo_address", lo_address_o, mq[0].addr);
        check("pf_ready", pf_ready_o, mq.size() < D);
        check("drop_cnt", drop_cnt_o, m_drop);
        check("issue_cnt", issue_cnt_o, m_issue);
        obs_v = lo_valid_o;
        obs_a = lo_address_o;
        pop = (lv && rdy) || ((mq.size() != 0) && !mq[0].live);
        dup = 1'b0;
`ifdef PF_DEDUP_EN
        foreach (mq[i]) if (mq[i].live && line_of(mq[i].addr) == line_of(pa)) dup = 1'b1;
`endif
        acc = pv && (mq.size() < D) && !(dv && line_of(pa) == line_of(da)) && !dup;
        @(posedge clk);
        if (pop) begin
            if (lv && rdy) m_issue++;
            void'(mq.pop_front());
        end
        if (dv) foreach (mq[i]) if (line_of(mq[i].addr) == line_of(da)) mq[i].live = 1'b0;
        if (acc) mq.push_back('{addr: pa, live: 1'b1});
        else if (pv) m_drop++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        #2;
        pf_valid_i  = 1'b0;
        dmd_valid_i = 1'b0;
        lo_ready_i  = 1'b0;
        rst_n       = 1'b0;
        #1;
        mq.delete();
        m_drop  = 0;
        m_issue = 0;
        check("rst_lo_valid", lo_valid_o, 1'b0);
        check("rst_lo_address", lo_address_o, '0);
        check("rst_pf_ready", pf_ready_o, 1'b1);
        check("rst_drop_cnt", drop_cnt_o, '0);
        check("rst_issue_cnt", issue_cnt_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_drop = 0;
        m_issue = 0;
        do_reset();

        // T1: reset with three entries queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'h7000 + 64'(i * 64), 1'b0, '0, 1'b0);
        do_reset();

        // T2: fill past capacity, then drain in order
        for (int i = 0; i < 9; i++) cycle(1'b1, 64'h1000 + 64'(i * 64), 1'b0, '0, 1'b0);
        #1;
        check("t2_full_ready", pf_ready_o, 1'b0);
        check("t2_drop", drop_cnt_o, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
            check("t2_issue_valid", obs_v, 1'b1);
            check("t2_issue_addr", obs_a, 64'h1000 + 64'(i * 64));
        end
        #1;
        check("t2_issue_cnt", issue_cnt_o, 8);
        do_reset();

        // T3: demand priority blocks issue
        cycle(1'b1, 64'h2000, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 64'h5000, 1'b1);
            check("t3_blocked", obs_v, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("t3_valid", obs_v, 1'b1);
        check("t3_addr", obs_a, 64'h2000);
        #1;
        check("t3_issue_cnt", issue_cnt_o, 1);
        do_reset();

        // T4: demand cancel of head and of an incoming request
        cycle(1'b1, 64'h3000, 1'b0, '0, 1'b0);
        cycle(1'b1, 64'h3040, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 64'h3010, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("t4_dead_head", obs_v, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("t4_valid", obs_v, 1'b1);
        check("t4_addr", obs_a, 64'h3040);
        idle(1, 1'b1);
        #1;
        check("t4_issue_cnt", issue_cnt_o, 1);
        cycle(1'b1, 64'h3020, 1'b1, 64'h3000, 1'b1);
        #1;
        check("t4_drop_cnt", drop_cnt_o, 1);
        do_reset();

        // T5: same line twice
        cycle(1'b1, 64'h4000, 1'b0, '0, 1'b0);
        cycle(1'b1, 64'h4008, 1'b0, '0, 1'b0);
        #1;
`ifdef PF_DEDUP_EN
        check("t5_drop_cnt", drop_cnt_o, 1);
`else
        check("t5_drop_cnt", drop_cnt_o, 0);
`endif
        idle(3, 1'b1);
        #1;
`ifdef PF_DEDUP_EN
        check("t5_issue_cnt", issue_cnt_o, 1);
`else
        check("t5_issue_cnt", issue_cnt_o, 2);
`endif
        do_reset();

        // T6: random traffic over a small set of lines to force collisions and wrap
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] pa, da;
            pa = 64'h8000 + 64'($urandom_range(0, 15) << LL) + 64'($urandom_range(0, 63));
            da = 64'h8000 + 64'($urandom_range(0, 15) << LL) + 64'($urandom_range(0, 63));
            cycle($urandom_range(0, 99) < 55, pa, $urandom_range(0, 99) < 20, da,
                  $urandom_range(0, 99) < 45);
        end
        idle(12, 1'b1);
        check("t6_drained", pf_ready_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
